// File: rtl/lb_arbiter_if.sv
// Local-bus (LB) handshake bundle shared by the bridges, the arbiter and the register map.
// The master modport issues write/read requests; the slave modport answers them.
interface lb_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned STRB_W = DATA_W / 8
);

  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wen;
  logic              wready;
  logic [ADDR_W-1:0] raddr;
  logic              ren;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;

  modport master (
    output waddr, wdata, wstrb, wen, raddr, ren,
    input  wready, rdata, rvalid
  );

  modport slave (
    input  waddr, wdata, wstrb, wen, raddr, ren,
    output wready, rdata, rvalid
  );

endinterface

// File: rtl/lb_arbiter.sv
// Two-master round-robin arbiter for the local bus. One transaction in flight at a time; the
// grant is registered so the slave sees a request one cycle after the master raises it.
// Optional slave-response timeout is enabled by defining LB_ARB_TIMEOUT_EN.
module lb_arbiter #(
  parameter int unsigned       ADDR_W        = 16,
  parameter int unsigned       DATA_W        = 32,
  parameter int unsigned       STRB_W        = DATA_W / 8,
  parameter int unsigned       TIMEOUT_CYC   = 256,
  parameter logic [DATA_W-1:0] TIMEOUT_RDATA = 32'hDEADDEAD
) (
  input  logic         clk,
  input  logic         rst,
  lb_arbiter_if.slave  m0_io,
  lb_arbiter_if.slave  m1_io,
  lb_arbiter_if.master s_io,
  output logic         gnt,
  output logic         busy,
  output logic         tmo
);

  typedef enum logic [1:0] {StIdle, StWrite, StRead} state_e;

  state_e state_q;
  logic   gnt_q;
  logic   rr_ptr_q;

  logic              req0, req1;
  logic              grant_idx;
  logic              grant_wen;
  logic              in_write, in_read;
  logic              wr_done, rd_done;
  logic              tmo_hit;
  logic [ADDR_W-1:0] sel_waddr;
  logic [DATA_W-1:0] sel_wdata;
  logic [STRB_W-1:0] sel_wstrb;
  logic [ADDR_W-1:0] sel_raddr;
  logic [DATA_W-1:0] rd_data;

  // Request decode and round-robin pick; rr_ptr only matters when both masters request.
  always_comb begin
    req0      = m0_io.wen | m0_io.ren;
    req1      = m1_io.wen | m1_io.ren;
    grant_idx = (req0 && req1) ? rr_ptr_q : req1;
    grant_wen = grant_idx ? m1_io.wen : m0_io.wen;
  end

  // Route the granted master's bus fields toward the slave.
  always_comb begin
    sel_waddr = gnt_q ? m1_io.waddr : m0_io.waddr;
    sel_wdata = gnt_q ? m1_io.wdata : m0_io.wdata;
    sel_wstrb = gnt_q ? m1_io.wstrb : m0_io.wstrb;
    sel_raddr = gnt_q ? m1_io.raddr : m0_io.raddr;
  end

`ifdef LB_ARB_TIMEOUT_EN
  localparam int unsigned     CntW    = $clog2(TIMEOUT_CYC);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

  logic [CntW-1:0] cnt_q;

  // Timeout fires only when the slave stays silent in the last counted cycle; a late response
  // in that same cycle still completes normally.
  always_comb begin
    tmo_hit = 1'b0;
    if (cnt_q == CntLast) begin
      tmo_hit = (state_q == StWrite && !s_io.wready) || (state_q == StRead && !s_io.rvalid);
    end
  end

  // Cycle counter: cleared on entry to WRITE/READ, counts every cycle spent there.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (state_q == StIdle) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  logic unused_cfg;

  // Without the timeout the arbiter waits forever for the slave.
  always_comb begin
    tmo_hit    = 1'b0;
    unused_cfg = ^TIMEOUT_CYC;
  end
`endif

  // Completion strobes: slave response, or a forced completion on timeout.
  always_comb begin
    in_write = (state_q == StWrite);
    in_read  = (state_q == StRead);
    wr_done  = in_write && (s_io.wready || tmo_hit);
    rd_done  = in_read && (s_io.rvalid || tmo_hit);
    rd_data  = s_io.rvalid ? s_io.rdata : TIMEOUT_RDATA;
  end

  // Arbitration FSM: grant and round-robin pointer update only when leaving IDLE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      gnt_q    <= 1'b0;
      rr_ptr_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req0 || req1) begin
            gnt_q    <= grant_idx;
            rr_ptr_q <= ~grant_idx;
            state_q  <= grant_wen ? StWrite : StRead;
          end
        end
        StWrite: begin
          if (wr_done) state_q <= StIdle;
        end
        StRead: begin
          if (rd_done) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Slave-side drive: zero whenever the corresponding transaction is not active.
  always_comb begin
    s_io.wen   = in_write && !tmo_hit;
    s_io.ren   = in_read && !tmo_hit;
    s_io.waddr = in_write ? sel_waddr : '0;
    s_io.wdata = in_write ? sel_wdata : '0;
    s_io.wstrb = in_write ? sel_wstrb : '0;
    s_io.raddr = in_read ? sel_raddr : '0;
  end

  // Master-side responses: only the granted master ever sees a pulse or read data.
  always_comb begin
    m0_io.wready = wr_done && !gnt_q;
    m0_io.rvalid = rd_done && !gnt_q;
    m0_io.rdata  = (rd_done && !gnt_q) ? rd_data : '0;
    m1_io.wready = wr_done && gnt_q;
    m1_io.rvalid = rd_done && gnt_q;
    m1_io.rdata  = (rd_done && gnt_q) ? rd_data : '0;
  end

  // Status outputs.
  always_comb begin
    gnt  = gnt_q;
    busy = (state_q != StIdle);
    tmo  = tmo_hit;
  end

endmodule
